// File: rtl/fm_mix_dsm.sv
// rtl/fm_mix_dsm.sv - four-voice volume mixer with sequential MAC and first-order delta-sigma DAC
//
// Purpose: snapshots four 12-bit voice samples once per CLK_DIV cycles, scales each by a
// 4-bit volume, sums them over four cycles with one multiplier, and exports the
// truncated 14-bit mix as PCM and as a 1-bit delta-sigma bitstream.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   sample_raw_1..4  [11:0]    unsigned voice samples (free-running)
//   vol_we, vol_sel, vol_data  volume register write port (one write per cycle)
//   mix_out          [13:0]    registered mixed PCM, (sum of products) >> 4
//   mix_valid                  one-cycle pulse when mix_out updates
//   dsm_out                    delta-sigma bitstream, ones density = dsm_in / 16384
//
// Configuration: FM_MIX_DITHER_EN adds a 16-bit LFSR dither ahead of the modulator.

module fm_mix_dsm #(
    parameter int CLK_DIV  = 256,
    parameter int SAMPLE_W = 12,
    parameter int VOL_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_raw_1,
    input  logic [SAMPLE_W-1:0] sample_raw_2,
    input  logic [SAMPLE_W-1:0] sample_raw_3,
    input  logic [SAMPLE_W-1:0] sample_raw_4,
    input  logic                vol_we,
    input  logic [1:0]          vol_sel,
    input  logic [VOL_W-1:0]    vol_data,
    output logic [13:0]         mix_out,
    output logic                mix_valid,
    output logic                dsm_out
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int                PROD_W   = SAMPLE_W + VOL_W;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [VOL_W-1:0]    vol   [4];
    logic [SAMPLE_W-1:0] snap  [4];
    logic [VOL_W-1:0]    vsnap [4];
    logic [17:0]         acc;
    logic [1:0]          ch;
    logic [PROD_W-1:0]   prod;
    logic [17:0]         acc_sum;
    logic                do_load;
    logic                do_acc;
    logic                do_done;
    logic [13:0]         dsm_in;
    logic [13:0]         dsm_acc;
    logic [14:0]         dsm_sum;

    // Sample-rate divider: free-running, independent of the MAC state.
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Volume registers; frames only see them through vsnap, so a write lands next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                vol[i] <= '1;
            end
        end else if (vol_we) begin
            vol[vol_sel] <= vol_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and datapath controls. A tick while in ACC is dropped.
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_acc    = 1'b0;
        do_done   = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    do_load   = 1'b1;
                    state_nxt = ACC;
                end
            end
            ACC: begin
                do_acc = 1'b1;
                if (ch == 2'd3) begin
                    do_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One multiplier shared across the four channels.
    always_comb begin
        prod    = PROD_W'(snap[ch]) * PROD_W'(vsnap[ch]);
        acc_sum = acc + 18'(prod);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            ch        <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap[i]  <= '0;
                vsnap[i] <= '0;
            end
        end else begin
            mix_valid <= 1'b0;
            if (do_load) begin
                snap[0]  <= sample_raw_1;
                snap[1]  <= sample_raw_2;
                snap[2]  <= sample_raw_3;
                snap[3]  <= sample_raw_4;
                for (int i = 0; i < 4; i++) begin
                    vsnap[i] <= vol[i];
                end
                acc <= '0;
                ch  <= '0;
            end else if (do_acc) begin
                acc <= acc_sum;
                ch  <= ch + 1'b1;
            end
            if (do_done) begin
                // Full-scale sum is 245700, so the truncated >>4 never exceeds 14 bits.
                mix_out   <= acc_sum[17:4];
                mix_valid <= 1'b1;
            end
        end
    end

`ifdef FM_MIX_DITHER_EN
    logic [15:0] lfsr;
    logic [14:0] dith_sum;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Zero-mean-ish dither of -1..+2 LSB, clamped to the modulator's input range.
    always_comb begin
        dith_sum = {1'b0, mix_out} + {13'b0, lfsr[1:0]};
        if (dith_sum == 15'd0) begin
            dsm_in = 14'd0;
        end else if (dith_sum > 15'd16384) begin
            dsm_in = 14'h3FFF;
        end else begin
            dsm_in = 14'(dith_sum - 15'd1);
        end
    end
`else
    assign dsm_in = mix_out;
`endif

    // First-order delta-sigma: the accumulator overflow is the output bit.
    assign dsm_sum = {1'b0, dsm_acc} + {1'b0, dsm_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dsm_acc <= '0;
            dsm_out <= 1'b0;
        end else begin
            dsm_acc <= dsm_sum[13:0];
            dsm_out <= dsm_sum[14];
        end
    end

endmodule
